// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the core's instruction memory.
//
// Accepts a byte stream of LEN_LO, LEN_HI, then 4*N little-endian payload bytes,
// then an 8-bit checksum. The checksum is the mod-256 sum of every earlier byte.
// Each assembled word is written at incrementing byte addresses. The core is held
// in reset until a load completes with a matching checksum.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   start              one-cycle load request (honoured in IDLE, DONE, ERR)
//   byte_valid/_data   input byte stream
//   byte_ready         loader accepts a byte this cycle
//   we, waddr, wdata   instruction-memory write port (one-cycle strobe per word)
//   core_rst_n         active-low core reset; high only after a good load
//   busy, done, error  load status
module imem_loader #(
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [15:0] MaxLen = 16'(MAX_WORDS);

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StDone,
    StErr
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [1:0]  lane_q, lane_d;
  logic [23:0] buf_q, buf_d;
  logic [7:0]  sum_q, sum_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        byte_ready_q, byte_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        core_rst_n_q, core_rst_n_d;

  logic        xfer;
  logic        loading_d;

  // byte_ready is registered, so the handshake uses the registered copy.
  assign xfer = byte_valid & byte_ready_q;

  always_comb begin
    state_d    = state_q;
    len_lo_d   = len_lo_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    lane_d     = lane_q;
    buf_d      = buf_q;
    sum_d      = sum_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    // The address advances on the edge that ends each write pulse.
    waddr_d    = we_q ? waddr_q + 32'd4 : waddr_q;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLen0;
          waddr_d = 32'd0;
          sum_d   = 8'd0;
        end
      end

      StLen0: begin
        if (xfer) begin
          len_lo_d = byte_data;
          sum_d    = sum_q + byte_data;
          state_d  = StLen1;
        end
      end

      StLen1: begin
        if (xfer) begin
          len_d = {byte_data, len_lo_q};
          sum_d = sum_q + byte_data;
          if (len_d > MaxLen) begin
            state_d = StErr;
          end else if (len_d == 16'd0) begin
            state_d = StCsum;
          end else begin
            state_d    = StData;
            word_cnt_d = 16'd0;
            lane_d     = 2'd0;
          end
        end
      end

      StData: begin
        if (xfer) begin
          sum_d  = sum_q + byte_data;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: buf_d[7:0]   = byte_data;
            2'd1: buf_d[15:8]  = byte_data;
            2'd2: buf_d[23:16] = byte_data;
            default: begin
              // Top lane completes the word: write it straight from the buffer.
              we_d       = 1'b1;
              wdata_d    = {byte_data, buf_q};
              word_cnt_d = word_cnt_q + 16'd1;
              if (word_cnt_d == len_q) begin
                state_d = StCsum;
              end
            end
          endcase
        end
      end

      StCsum: begin
        if (xfer) begin
          state_d = (byte_data == sum_q) ? StDone : StErr;
        end
      end

      default: state_d = StIdle;
    endcase

    // Status outputs are registered copies of what the next state implies.
    loading_d    = (state_d == StLen0) || (state_d == StLen1) ||
                   (state_d == StData) || (state_d == StCsum);
    byte_ready_d = loading_d;
    busy_d       = loading_d;
    done_d       = (state_d == StDone);
    error_d      = (state_d == StErr);
    core_rst_n_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      len_lo_q     <= 8'd0;
      len_q        <= 16'd0;
      word_cnt_q   <= 16'd0;
      lane_q       <= 2'd0;
      buf_q        <= 24'd0;
      sum_q        <= 8'd0;
      waddr_q      <= 32'd0;
      wdata_q      <= 32'd0;
      we_q         <= 1'b0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      lane_q       <= lane_d;
      buf_q        <= buf_d;
      sum_q        <= sum_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_rst_n_q <= core_rst_n_d;
    end
  end

  assign byte_ready = byte_ready_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes go into a scoreboard
// queue as stimulus is built and are popped as the loader pulses we.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        core_rst_n;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.MAX_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .core_rst_n (core_rst_n),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_count = 0;
  logic [63:0] exp_q[$];
  logic [7:0]  stream[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {byte_ready, busy, done, error, core_rst_n, we}
  function automatic logic [63:0] status();
    return {58'd0, byte_ready, busy, done, error, core_rst_n, we};
  endfunction

  localparam logic [63:0] StatReset = 64'b000000;
  localparam logic [63:0] StatLoad  = 64'b110000;
  localparam logic [63:0] StatGood  = 64'b001010;
  localparam logic [63:0] StatBad   = 64'b000100;

  // Write monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst && we) begin
      logic [63:0] e;
      we_count++;
      if (exp_q.size() == 0) begin
        check("we_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("we_write", {waddr, wdata}, e);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      check("ready_timeout", 64'd0, 64'd1);
    end else begin
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic run_load(input int max_gap, input bit inject);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("status_after_start", status(), StatLoad);
    foreach (stream[i]) begin
      if (i > 0 && max_gap > 0) begin
        int g = int'($urandom_range(max_gap, 0));
        for (int k = 0; k < g; k++) begin
          if (inject && $urandom_range(1, 0) == 1) start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      send_byte(stream[i]);
    end
  endtask

  task automatic push_good_writes();
    exp_q.push_back({32'd0, 32'h0000_0013});
    exp_q.push_back({32'd4, 32'hDEAD_BEEF});
  endtask

  task automatic set_good_stream(input logic [7:0] csum);
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, csum};
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_status", status(), StatReset);
    check("reset_waddr", {32'd0, waddr}, 64'd0);
    check("reset_wdata", {32'd0, wdata}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_status", status(), StatReset);

    // Good load, N=2.
    we_count = 0;
    set_good_stream(8'h4D);
    push_good_writes();
    run_load(0, 1'b0);
    check("good_status", status(), StatGood);
    check("good_we_count", 64'(we_count), 64'd2);
    check("good_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check("good_status_hold", status(), StatGood);

    // Empty program from DONE.
    we_count = 0;
    stream = '{8'h00, 8'h00, 8'h00};
    run_load(0, 1'b0);
    check("empty_status", status(), StatGood);
    check("empty_we_count", 64'(we_count), 64'd0);

    // Over-length: N = 1025.
    we_count = 0;
    stream = '{8'h01, 8'h04};
    run_load(0, 1'b0);
    check("overlen_status", status(), StatBad);
    repeat (2) @(negedge clk);
    check("overlen_status_hold", status(), StatBad);
    check("overlen_we_count", 64'(we_count), 64'd0);

    // Bad checksum, started from ERR.
    we_count = 0;
    set_good_stream(8'h4C);
    push_good_writes();
    run_load(0, 1'b0);
    check("badsum_status", status(), StatBad);
    check("badsum_we_count", 64'(we_count), 64'd2);
    check("badsum_queue_empty", 64'(exp_q.size()), 64'd0);

    // Throttled stream with stray start pulses mid-load.
    for (int r = 0; r < 3; r++) begin
      we_count = 0;
      set_good_stream(8'h4D);
      push_good_writes();
      run_load(3, 1'b1);
      check("throttle_status", status(), StatGood);
      check("throttle_we_count", 64'(we_count), 64'd2);
      check("throttle_queue_empty", 64'(exp_q.size()), 64'd0);
    end

    // Reset after the 6th byte; the first word write is already in flight.
    we_count = 0;
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    exp_q.push_back({32'd0, 32'h0000_0013});
    run_load(0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("midrst_status", status(), StatReset);
    check("midrst_waddr", {32'd0, waddr}, 64'd0);
    check("midrst_wdata", {32'd0, wdata}, 64'd0);
    check("midrst_queue_empty", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_idle", status(), StatReset);

    we_count = 0;
    set_good_stream(8'h4D);
    push_good_writes();
    run_load(1, 1'b0);
    check("after_rst_status", status(), StatGood);
    check("after_rst_we_count", 64'(we_count), 64'd2);
    check("after_rst_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
